mission_sequencer: RTL and testbench
====================================

// Module: mission_sequencer
// PURPOSE
// Top-level leg sequencer for the line-tracking car. Drives en_tracking/en_uturn of the
// tracking/u-turn unit, alternating track legs and u-turns for LEGS legs, inserting a
// motor-stop settle gap between phases. Reports progress, completion and (optionally) a stall fault.
// PARAMETERS
// LEGS            2     number of track legs per mission (>=1); a u-turn follows every leg but the last
// SETTLE_CYCLES   8     cycles motor_stop is held between phases (>=1)
// TIMEOUT_CYCLES  4096  watchdog limit per TRACK/UTURN phase (used only with MISSION_WDOG_EN)
// CNT_W           16    width of settle/watchdog counter; must hold max(SETTLE_CYCLES,TIMEOUT_CYCLES)
// PORTS
// clk             in   1  system clock
// rst             in   1  asynchronous reset, active-high
// start           in   1  begin mission (sampled in IDLE only)
// abort           in   1  cancel mission / clear fault
// end_of_track    in   1  from tracking unit; rising edge = leg finished
// uturn_finished  in   1  from tracking unit; rising edge = u-turn finished
// en_tracking     out  1  enable tracking phase
// en_uturn        out  1  enable u-turn phase
// motor_stop      out  1  force drive motor idle (settle)
// busy            out  1  state not IDLE/FAULT
// done            out  1  one-cycle pulse at mission completion
// fault           out  1  watchdog fault, held until abort
// leg_count       out  4  index of current leg, 0-based
// state           out  3  FSM state code (debug)
// BEHAVIOUR
// - Reset (async, any time incl. mid-mission): state=IDLE, all outputs 0, counters 0, edge regs 0.
// - Moore FSM; all outputs decoded from registered state, so an input sampled at edge k takes effect after edge k.
// - States: IDLE=0 TRACK=1 SETTLE_T=2 UTURN=3 SETTLE_U=4 DONE=5 FAULT=6.
// - IDLE: start -> TRACK, leg_count<=0.
// - TRACK: en_tracking=1. Rising edge of end_of_track -> SETTLE_T.
// - SETTLE_T: motor_stop=1 for exactly SETTLE_CYCLES cycles; then leg_count==LEGS-1 -> DONE, else -> UTURN.
// - UTURN: en_uturn=1. Rising edge of uturn_finished -> SETTLE_U.
// - SETTLE_U: motor_stop=1 for SETTLE_CYCLES cycles; leg_count<=leg_count+1, -> TRACK.
// - DONE: done=1 for one cycle, -> IDLE; leg_count keeps final value until next start.
// - Edge detect: prev regs sampled every cycle; a level already high on phase entry is not an
//   event; it must fall and rise again. Events outside their phase are ignored.
// - en_tracking, en_uturn, motor_stop mutually exclusive in every state.
// - Priority per cycle: abort > watchdog expiry vs phase event (event wins) > normal transition.
// - abort in any state other than IDLE -> IDLE next edge, enables 0, no done pulse, fault cleared.
// - start while busy or in FAULT ignored; start and abort same cycle in IDLE -> stays IDLE.
// - Settle counter loads 0 on entry, exits when count==SETTLE_CYCLES-1; no wrap possible.
// CONFIGURATION
// - MISSION_WDOG_EN defined: counter runs in TRACK/UTURN (cleared on entry); reaching
//   TIMEOUT_CYCLES-1 without the phase event -> FAULT: fault=1, enables 0, motor_stop=1,
//   busy=0; only abort (or rst) leaves FAULT -> IDLE.
// - Not defined: no watchdog logic, FAULT unreachable, fault tied 0, phases wait indefinitely.
// TESTING (LEGS=2, SETTLE_CYCLES=4, TIMEOUT_CYCLES=64, MISSION_WDOG_EN defined unless noted)
// 1 rst pulse mid-UTURN -> immediately en_uturn=0, state=0, leg_count=0, fault=0, done=0.
// 2 start; end_of_track rise; uturn_finished rise; end_of_track rise -> state 1,2(4 cyc),3,4(4 cyc),
//   1 with leg_count=1, 2(4 cyc), done=1 for exactly one cycle, then IDLE, leg_count=1.
// 3 abort during UTURN -> next edge en_uturn=0, state=0, busy=0, done never asserted.
// 4 TRACK with end_of_track low 64 cycles -> state=6, fault=1, en_tracking=0; start ignored; abort -> state=0, fault=0.
// 5 end_of_track held high on re-entry to TRACK (leg 1) -> no transition until it drops low and rises again.
// 6 MISSION_WDOG_EN undefined: TRACK idle 200 cycles -> stays state=1, fault=0; start while busy ignored.

Source files
------------

// File: rtl/mission_sequencer.sv
// Leg sequencer for the line-tracking car: alternates track legs and u-turns with a motor-stop settle gap.
// Optional stall watchdog enabled by defining MISSION_WDOG_EN.
module mission_sequencer #(
    parameter int LEGS           = 2,
    parameter int SETTLE_CYCLES  = 8,
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int CNT_W          = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic       end_of_track,
    input  logic       uturn_finished,
    output logic       en_tracking,
    output logic       en_uturn,
    output logic       motor_stop,
    output logic       busy,
    output logic       done,
    output logic       fault,
    output logic [3:0] leg_count,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_TRACK    = 3'd1,
        S_SETTLE_T = 3'd2,
        S_UTURN    = 3'd3,
        S_SETTLE_U = 3'd4,
        S_DONE     = 3'd5,
        S_FAULT    = 3'd6
    } state_e;

    localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]       LAST_LEG     = 4'(LEGS - 1);

    // The shared counter must reach both terminal counts without wrapping.
    if ((longint'(SETTLE_CYCLES) > (longint'(1) << CNT_W)) ||
        (longint'(TIMEOUT_CYCLES) > (longint'(1) << CNT_W))) begin : g_cnt_w_check
        $error("CNT_W too narrow for SETTLE_CYCLES/TIMEOUT_CYCLES");
    end

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       leg_q, leg_d;
    logic             eot_prev_q, uf_prev_q;
    logic             eot_rise, uf_rise;
    logic             wdog_expired;

    assign eot_rise = end_of_track & ~eot_prev_q;
    assign uf_rise  = uturn_finished & ~uf_prev_q;

`ifdef MISSION_WDOG_EN
    assign wdog_expired = (cnt_q == TIMEOUT_LAST);
`else
    assign wdog_expired = 1'b0;
`endif

    // Counter defaults to 0 so every state entry starts a fresh count.
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        leg_d   = leg_q;
        if (abort && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start && !abort) begin
                        state_d = S_TRACK;
                        leg_d   = '0;
                    end
                end
                S_TRACK: begin
                    if (eot_rise)          state_d = S_SETTLE_T;
                    else if (wdog_expired) state_d = S_FAULT;
`ifdef MISSION_WDOG_EN
                    else                   cnt_d   = cnt_q + 1'b1;
`endif
                end
                S_SETTLE_T: begin
                    if (cnt_q == SETTLE_LAST) state_d = (leg_q == LAST_LEG) ? S_DONE : S_UTURN;
                    else                      cnt_d   = cnt_q + 1'b1;
                end
                S_UTURN: begin
                    if (uf_rise)           state_d = S_SETTLE_U;
                    else if (wdog_expired) state_d = S_FAULT;
`ifdef MISSION_WDOG_EN
                    else                   cnt_d   = cnt_q + 1'b1;
`endif
                end
                S_SETTLE_U: begin
                    if (cnt_q == SETTLE_LAST) begin
                        state_d = S_TRACK;
                        leg_d   = leg_q + 4'd1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_DONE:  state_d = S_IDLE;
                S_FAULT: state_d = S_FAULT;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Outputs are registered from the next state so they always match state_q.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            leg_q       <= '0;
            eot_prev_q  <= 1'b0;
            uf_prev_q   <= 1'b0;
            en_tracking <= 1'b0;
            en_uturn    <= 1'b0;
            motor_stop  <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            leg_q       <= leg_d;
            eot_prev_q  <= end_of_track;
            uf_prev_q   <= uturn_finished;
            en_tracking <= (state_d == S_TRACK);
            en_uturn    <= (state_d == S_UTURN);
            motor_stop  <= (state_d == S_SETTLE_T) || (state_d == S_SETTLE_U) || (state_d == S_FAULT);
            busy        <= (state_d != S_IDLE) && (state_d != S_FAULT);
            done        <= (state_d == S_DONE);
        end
    end

`ifdef MISSION_WDOG_EN
    logic fault_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) fault_q <= 1'b0;
        else     fault_q <= (state_d == S_FAULT);
    end
    assign fault = fault_q;
`else
    assign fault = 1'b0;
`endif

    assign leg_count = leg_q;
    assign state     = state_q;

endmodule

// File: tb/tb_mission_sequencer.sv
// Bench for mission_sequencer: directed mission scenarios plus random input traffic,
// checked every cycle against a phase/countdown model of the sequencer.
module tb_mission_sequencer;

    localparam int LEGS    = 2;
    localparam int SETTLE  = 4;
    localparam int TIMEOUT = 64;
`ifdef MISSION_WDOG_EN
    localparam bit WDOG = 1'b1;
`else
    localparam bit WDOG = 1'b0;
`endif

    localparam int ST_IDLE = 0, ST_TRACK = 1, ST_SETTLE_T = 2, ST_UTURN = 3,
                   ST_SETTLE_U = 4, ST_DONE = 5, ST_FAULT = 6;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0, abort = 1'b0, end_of_track = 1'b0, uturn_finished = 1'b0;
    logic       en_tracking, en_uturn, motor_stop, busy, done, fault;
    logic [3:0] leg_count;
    logic [2:0] state;

    mission_sequencer #(
        .LEGS(LEGS), .SETTLE_CYCLES(SETTLE), .TIMEOUT_CYCLES(TIMEOUT), .CNT_W(16)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .end_of_track(end_of_track), .uturn_finished(uturn_finished),
        .en_tracking(en_tracking), .en_uturn(en_uturn), .motor_stop(motor_stop),
        .busy(busy), .done(done), .fault(fault), .leg_count(leg_count), .state(state)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    int done_seen = 0;

    // Reference: current phase, settle cycles still to go, cycles spent in a phase, leg index.
    int m_state, m_left, m_wd, m_leg;
    bit m_pe, m_pu;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = ST_IDLE; m_left = 0; m_wd = 0; m_leg = 0; m_pe = 0; m_pu = 0;
    endtask

    task automatic model_step(input logic s, input logic a, input logic e, input logic u);
        bit re;
        bit ru;
        re = e && !m_pe;
        ru = u && !m_pu;
        m_pe = e;
        m_pu = u;
        if (a && m_state != ST_IDLE) begin
            m_state = ST_IDLE;
        end else begin
            case (m_state)
                ST_IDLE: if (s && !a) begin m_state = ST_TRACK; m_leg = 0; m_wd = 0; end
                ST_TRACK: begin
                    if (re) begin m_state = ST_SETTLE_T; m_left = SETTLE; end
                    else if (WDOG && m_wd + 1 >= TIMEOUT) m_state = ST_FAULT;
                    else m_wd++;
                end
                ST_SETTLE_T: begin
                    m_left--;
                    if (m_left == 0) begin
                        if (m_leg == LEGS - 1) m_state = ST_DONE;
                        else begin m_state = ST_UTURN; m_wd = 0; end
                    end
                end
                ST_UTURN: begin
                    if (ru) begin m_state = ST_SETTLE_U; m_left = SETTLE; end
                    else if (WDOG && m_wd + 1 >= TIMEOUT) m_state = ST_FAULT;
                    else m_wd++;
                end
                ST_SETTLE_U: begin
                    m_left--;
                    if (m_left == 0) begin m_leg++; m_state = ST_TRACK; m_wd = 0; end
                end
                ST_DONE:  m_state = ST_IDLE;
                default:  m_state = m_state;
            endcase
        end
    endtask

    task automatic check_all(input string tag);
        logic [5:0] exp_o;
        exp_o = {m_state == ST_TRACK, m_state == ST_UTURN,
                 m_state == ST_SETTLE_T || m_state == ST_SETTLE_U || m_state == ST_FAULT,
                 m_state != ST_IDLE && m_state != ST_FAULT,
                 m_state == ST_DONE, m_state == ST_FAULT};
        chk({tag, "_state"}, 32'(state), m_state);
        chk({tag, "_leg"}, 32'(leg_count), m_leg);
        chk({tag, "_outs"}, 32'({en_tracking, en_uturn, motor_stop, busy, done, fault}), 32'(exp_o));
    endtask

    task automatic step(input logic s, input logic a, input logic e, input logic u);
        @(negedge clk);
        start = s; abort = a; end_of_track = e; uturn_finished = u;
        @(posedge clk);
        model_step(s, a, e, u);
        #1;
        if (done) done_seen++;
        check_all("cyc");
    endtask

    task automatic async_reset(input string tag);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_all(tag);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic e_lvl, u_lvl;
        model_reset();
        repeat (2) @(negedge clk);
        #1 check_all("reset");
        @(negedge clk);
        rst = 1'b0;

        // Full two-leg mission
        done_seen = 0;
        step(1, 0, 0, 0);
        chk("t2_track", 32'(state), ST_TRACK);
        step(0, 0, 0, 0); step(0, 0, 0, 0);
        step(0, 0, 1, 0);
        repeat (SETTLE) step(0, 0, 1, 0);
        chk("t2_uturn", 32'(state), ST_UTURN);
        step(0, 0, 0, 0); step(0, 0, 0, 1);
        repeat (SETTLE) step(0, 0, 0, 1);
        chk("t2_leg1", 32'(leg_count), 1);
        step(0, 0, 0, 0); step(0, 0, 1, 0);
        repeat (SETTLE) step(0, 0, 0, 0);
        chk("t2_done", 32'(done), 1);
        step(0, 0, 0, 0);
        chk("t2_idle_leg", 32'({state, leg_count}), 32'({3'd0, 4'd1}));
        chk("t2_done_pulses", done_seen, 1);

        // Abort during u-turn
        done_seen = 0;
        step(1, 0, 0, 0); step(0, 0, 1, 0);
        repeat (SETTLE) step(0, 0, 0, 0);
        step(0, 1, 0, 0);
        chk("t3_abort", 32'({state, busy, en_uturn}), 0);
        chk("t3_no_done", done_seen, 0);

        // Async reset in the middle of a u-turn
        step(1, 0, 0, 0); step(0, 0, 1, 0);
        repeat (SETTLE) step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        async_reset("t1_rst");
        chk("t1_rst_outs", 32'({en_uturn, state, leg_count, fault, done}), 0);

`ifdef MISSION_WDOG_EN
        // Stalled track leg trips the watchdog
        step(1, 0, 0, 0);
        repeat (TIMEOUT) step(0, 0, 0, 0);
        chk("t4_fault", 32'({state, fault, en_tracking}), 32'({3'd6, 1'b1, 1'b0}));
        step(1, 0, 0, 0);
        chk("t4_start_ign", 32'(state), ST_FAULT);
        step(0, 1, 0, 0);
        chk("t4_abort", 32'({state, fault}), 0);
`else
        // Without the watchdog a stalled leg waits forever
        step(1, 0, 0, 0);
        repeat (200) step(0, 0, 0, 0);
        chk("t6_wait", 32'({state, fault}), 32'({3'd1, 1'b0}));
        step(1, 0, 0, 0);
        chk("t6_start_ign", 32'({state, leg_count}), 32'({3'd1, 4'd0}));
        step(0, 1, 0, 0);
`endif

        // end_of_track already high when leg 1 begins
        step(1, 0, 0, 0); step(0, 0, 1, 0);
        repeat (SETTLE) step(0, 0, 1, 0);
        step(0, 0, 1, 0); step(0, 0, 1, 1);
        repeat (SETTLE) step(0, 0, 1, 1);
        repeat (10) step(0, 0, 1, 0);
        chk("t5_held", 32'({state, leg_count}), 32'({3'd1, 4'd1}));
        step(0, 0, 0, 0); step(0, 0, 1, 0);
        chk("t5_rise", 32'(state), ST_SETTLE_T);
        step(0, 1, 0, 0);

        // Random traffic
        e_lvl = 1'b0;
        u_lvl = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 5) == 0) e_lvl = ~e_lvl;
            if ($urandom_range(0, 5) == 0) u_lvl = ~u_lvl;
            if ($urandom_range(0, 599) == 0) async_reset("rnd_rst");
            else step($urandom_range(0, 3) == 0, $urandom_range(0, 39) == 0, e_lvl, u_lvl);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
